// File: rtl/vga_pkg.sv
// Shared VGA constants and the rectangle position FSM state type for the
// 800x600@60 pixel pipeline.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int CNT_W    = 11;
    localparam int RGB_W    = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        UPDATE = 2'd2
    } pos_state_t;

endpackage

// File: rtl/rect_pos_ctl.sv
// Rectangle position controller: detects the start of vertical blanking and,
// while animation is enabled, moves the rectangle once per frame, bouncing it
// off the screen edges.
module rect_pos_ctl
    import vga_pkg::*;
#(
    parameter int RECT_W   = 64,
    parameter int RECT_H   = 48,
    parameter int STEP     = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             vblnk_in,
    output logic [CNT_W-1:0] xpos,
    output logic [CNT_W-1:0] ypos
);

    // One bit wider than the counters so position + STEP cannot wrap.
    localparam logic [CNT_W:0] X_MAX  = (CNT_W+1)'(H_ACTIVE - RECT_W);
    localparam logic [CNT_W:0] Y_MAX  = (CNT_W+1)'(V_ACTIVE - RECT_H);
    localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(STEP);

    pos_state_t     state;
    pos_state_t     state_nxt;
    logic           vblnk_q;
    logic           vblnk_rise;
    logic           upd;
    logic           dx;
    logic           dy;
    logic [CNT_W:0] x_inc;
    logic [CNT_W:0] y_inc;

    assign vblnk_rise = vblnk_in & ~vblnk_q;
    assign x_inc      = {1'b0, xpos} + STEP_W;
    assign y_inc      = {1'b0, ypos} + STEP_W;

    // Delayed copy of vblank for the frame-tick edge detector.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) vblnk_q <= 1'b0;
        else      vblnk_q <= vblnk_in;
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state; a frame tick seen outside ARMED is dropped, not queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = ARMED;
            ARMED:   if (!enable) state_nxt = IDLE;
                     else if (vblnk_rise) state_nxt = UPDATE;
            UPDATE:  state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output: the single cycle in which the position moves.
    always_comb begin
        upd = (state == UPDATE);
    end

    // Position and direction; each axis bounces independently.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            xpos <= '0;
            ypos <= '0;
            dx   <= 1'b1;
            dy   <= 1'b1;
        end else if (upd) begin
            if (dx) begin
                if (x_inc >= X_MAX) begin
                    xpos <= X_MAX[CNT_W-1:0];
                    dx   <= 1'b0;
                end else begin
                    xpos <= x_inc[CNT_W-1:0];
                end
            end else begin
                if ({1'b0, xpos} <= STEP_W) begin
                    xpos <= '0;
                    dx   <= 1'b1;
                end else begin
                    xpos <= xpos - STEP_W[CNT_W-1:0];
                end
            end
            if (dy) begin
                if (y_inc >= Y_MAX) begin
                    ypos <= Y_MAX[CNT_W-1:0];
                    dy   <= 1'b0;
                end else begin
                    ypos <= y_inc[CNT_W-1:0];
                end
            end else begin
                if ({1'b0, ypos} <= STEP_W) begin
                    ypos <= '0;
                    dy   <= 1'b1;
                end else begin
                    ypos <= ypos - STEP_W[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/draw_rect_bounce.sv
// Overlays a bouncing rectangle on the incoming pixel stream with a fixed
// two-cycle latency on colour and timing.
// Build option: define DRAW_RECT_OUTLINE_EN to draw only a 2-pixel border
// instead of a solid fill.
module draw_rect_bounce
    import vga_pkg::*;
#(
    parameter int               RECT_W     = 64,
    parameter int               RECT_H     = 48,
    parameter logic [RGB_W-1:0] RECT_COLOR = 12'hF80,
    parameter int               STEP       = 2,
    parameter int               H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int               V_ACTIVE   = vga_pkg::V_ACTIVE
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic [CNT_W-1:0] xpos,
    output logic [CNT_W-1:0] ypos
);

    logic [CNT_W:0]   h_ext;
    logic [CNT_W:0]   v_ext;
    logic [CNT_W:0]   x_lo;
    logic [CNT_W:0]   x_hi;
    logic [CNT_W:0]   y_lo;
    logic [CNT_W:0]   y_hi;
    logic             hit;

    logic [CNT_W-1:0] hcount_p1;
    logic [CNT_W-1:0] vcount_p1;
    logic             hsync_p1;
    logic             vsync_p1;
    logic             hblnk_p1;
    logic             vblnk_p1;
    logic [RGB_W-1:0] rgb_p1;
    logic             hit_p1;

    rect_pos_ctl #(
        .RECT_W   (RECT_W),
        .RECT_H   (RECT_H),
        .STEP     (STEP),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .pclk     (pclk),
        .rst      (rst),
        .enable   (enable),
        .vblnk_in (vblnk_in),
        .xpos     (xpos),
        .ypos     (ypos)
    );

    // Rectangle bounds are widened by one bit so the right/bottom edge never wraps.
    assign h_ext = {1'b0, hcount_in};
    assign v_ext = {1'b0, vcount_in};
    assign x_lo  = {1'b0, xpos};
    assign y_lo  = {1'b0, ypos};
    assign x_hi  = x_lo + (CNT_W+1)'(RECT_W);
    assign y_hi  = y_lo + (CNT_W+1)'(RECT_H);

    // Hit test against the frame-constant position; optionally limited to the border.
    always_comb begin
        hit = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);
`ifdef DRAW_RECT_OUTLINE_EN
        hit = hit && ((h_ext < x_lo + 12'd2) || (h_ext + 12'd2 >= x_hi) ||
                      (v_ext < y_lo + 12'd2) || (v_ext + 12'd2 >= y_hi));
`endif
    end

    // Stage 1: register timing, upstream colour and the hit flag.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_p1 <= '0;
            vcount_p1 <= '0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            hblnk_p1  <= 1'b0;
            vblnk_p1  <= 1'b0;
            rgb_p1    <= '0;
            hit_p1    <= 1'b0;
        end else begin
            hcount_p1 <= hcount_in;
            vcount_p1 <= vcount_in;
            hsync_p1  <= hsync_in;
            vsync_p1  <= vsync_in;
            hblnk_p1  <= hblnk_in;
            vblnk_p1  <= vblnk_in;
            rgb_p1    <= rgb_in;
            hit_p1    <= hit;
        end
    end

    // Stage 2: register timing and the composited colour; blanking forces black.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_p1;
            vcount_out <= vcount_p1;
            hsync_out  <= hsync_p1;
            vsync_out  <= vsync_p1;
            hblnk_out  <= hblnk_p1;
            vblnk_out  <= vblnk_p1;
            if (hblnk_p1 || vblnk_p1) rgb_out <= '0;
            else if (hit_p1)          rgb_out <= RECT_COLOR;
            else                      rgb_out <= rgb_p1;
        end
    end

endmodule
